// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one byte-laned memory,
// with fetch starvation protection and a one-cycle response stage.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef struct packed {
        logic valid;
        logic owner_d;
        logic is_write;
        logic err;
    } rsp_t;

    logic [CNT_W-1:0]  starve_q, starve_d;
    rsp_t              rsp_q, rsp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              starved, if_ok, d_ok;

    // Arbitration, memory request and response decode
    always_comb begin
        starved   = (starve_q == LIMIT);
        if_ok     = (if_addr[31:12] == 20'd1) && (if_addr[1:0] == 2'b00);
        d_ok      = (d_addr[31:12] == 20'd1) && (d_addr[1:0] == 2'b00);

        if_gnt    = rst_n & if_req & (~d_req | starved);
        d_gnt     = rst_n & d_req & ~if_gnt;

        mem_addr  = addr_q;
        mem_we    = 4'b0000;
        mem_wdata = 32'd0;
        if (if_gnt) begin
            mem_addr = if_addr[ADDR_W+1:2];
        end else if (d_gnt) begin
            mem_addr = d_addr[ADDR_W+1:2];
            if (d_we) begin
                mem_wdata = d_wdata;
                if (d_ok) mem_we = d_be;
            end
        end
        addr_d = mem_addr;

        starve_d = '0;
        if (if_req && !if_gnt) starve_d = starved ? starve_q : starve_q + CNT_W'(1);

        rsp_d = '0;
        if (if_gnt) begin
            rsp_d.valid = 1'b1;
            rsp_d.err   = ~if_ok;
        end else if (d_gnt) begin
            rsp_d.valid    = 1'b1;
            rsp_d.owner_d  = 1'b1;
            rsp_d.is_write = d_we;
            rsp_d.err      = ~d_ok;
        end

        // Gating with rst_n drops a response whose grant preceded reset
        if_rvalid = rst_n & rsp_q.valid & ~rsp_q.owner_d;
        d_rvalid  = rst_n & rsp_q.valid & rsp_q.owner_d;
        if_err    = if_rvalid & rsp_q.err;
        d_err     = d_rvalid & rsp_q.err;
        if_rdata  = (if_rvalid && !rsp_q.err) ? mem_rdata : 32'd0;
        d_rdata   = (d_rvalid && !rsp_q.err && !rsp_q.is_write) ? mem_rdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
            rsp_q    <= '0;
            addr_q   <= '0;
        end else begin
            starve_q <= starve_d;
            rsp_q    <= rsp_d;
            addr_q   <= addr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a behavioural model
// of arbitration, a golden word memory, and pending responses.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LIMIT  = 4;
    localparam int unsigned DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req, d_req, d_we;
    logic [31:0]       if_addr, d_addr, d_wdata;
    logic [3:0]        d_be;
    logic              if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
    logic [31:0]       if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'(i << 7);
    endfunction

    // Memory array attached to the DUT; reloaded with a known pattern in reset
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_word(i);
        end else begin
            for (int k = 0; k < 4; k++)
                if (mem_we[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
        mem_rdata <= mem[mem_addr];
    end

    // ---------------- reference model ----------------
    int                starve;
    logic [31:0]       gm [DEPTH];
    logic [ADDR_W-1:0] last_addr;
    bit                p_if_v, p_if_err, p_d_v, p_d_err;
    logic [31:0]       p_if_data, p_d_data;
    logic              e_if_gnt, e_d_gnt, e_if_rv, e_if_err, e_d_rv, e_d_err;
    logic [ADDR_W-1:0] e_addr;
    logic [3:0]        e_we;
    logic [31:0]       e_wdata, e_if_rdata, e_d_rdata;

    function automatic bit addr_ok(logic [31:0] a);
        return (a[31:12] == 20'd1) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [ADDR_W-1:0] widx(logic [31:0] a);
        return a[ADDR_W+1:2];
    endfunction

    task automatic model_comb();
        e_if_gnt   = rst_n && if_req && (!d_req || starve >= int'(LIMIT));
        e_d_gnt    = rst_n && d_req && !e_if_gnt;
        e_addr     = e_if_gnt ? widx(if_addr) : (e_d_gnt ? widx(d_addr) : last_addr);
        e_we       = (e_d_gnt && d_we && addr_ok(d_addr)) ? d_be : 4'b0000;
        e_wdata    = (e_d_gnt && d_we) ? d_wdata : 32'd0;
        e_if_rv    = rst_n && p_if_v;
        e_if_rdata = e_if_rv ? p_if_data : 32'd0;
        e_if_err   = e_if_rv && p_if_err;
        e_d_rv     = rst_n && p_d_v;
        e_d_rdata  = e_d_rv ? p_d_data : 32'd0;
        e_d_err    = e_d_rv && p_d_err;
    endtask

    task automatic model_adv();
        if (!rst_n) begin
            starve = 0; p_if_v = 0; p_d_v = 0; last_addr = '0;
            for (int i = 0; i < int'(DEPTH); i++) gm[i] = init_word(i);
        end else begin
            starve    = (if_req && !e_if_gnt) ? ((starve + 1 > int'(LIMIT)) ? int'(LIMIT) : starve + 1) : 0;
            p_if_v    = e_if_gnt;
            p_if_err  = !addr_ok(if_addr);
            p_if_data = addr_ok(if_addr) ? gm[widx(if_addr)] : 32'd0;
            p_d_v     = e_d_gnt;
            p_d_err   = !addr_ok(d_addr);
            p_d_data  = (addr_ok(d_addr) && !d_we) ? gm[widx(d_addr)] : 32'd0;
            if (e_d_gnt && d_we && addr_ok(d_addr))
                for (int k = 0; k < 4; k++)
                    if (d_be[k]) gm[widx(d_addr)][8*k +: 8] = d_wdata[8*k +: 8];
            last_addr = e_addr;
        end
    endtask

    // Drive one cycle of inputs after the edge, then settle to the falling edge
    task automatic apply(input logic r, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dd, input logic [3:0] be);
        @(posedge clk); #1;
        rst_n = r; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_be = be;
        @(negedge clk);
        model_comb();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b1, 32'h0000_1008, 1'b1, 1'b1, 32'h0000_1004, 32'h1234_5678, 4'hF);
            checks++; if ({if_gnt, d_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", {if_gnt, d_gnt}); end
            checks++; if (mem_we !== 4'b0000) begin errors++; $display("FAIL reset_we got=%b exp=0000", mem_we); end
            if (c > 0) begin
                checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
                checks++;
                if ({if_rvalid, d_rvalid, if_err, d_err} !== 4'b0000 || if_rdata !== 32'd0 || d_rdata !== 32'd0) begin
                    errors++; $display("FAIL reset_rsp got=%b/%h/%h exp=0", {if_rvalid, d_rvalid, if_err, d_err}, if_rdata, d_rdata);
                end
            end
            model_adv();
        end
    endtask

    task automatic test_fetch();
        logic [31:0] exp_word;
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        model_adv();
        exp_word = gm[2];
        apply(1'b1, 1'b1, 32'h0000_1008, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if ({if_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL fetch_gnt got=%b exp=10", {if_gnt, d_gnt}); end
        checks++; if (mem_addr !== 10'd2) begin errors++; $display("FAIL fetch_addr got=%0d exp=2", mem_addr); end
        model_adv();
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if ({if_rvalid, if_err, d_rvalid} !== 3'b100) begin errors++; $display("FAIL fetch_rsp got=%b exp=100", {if_rvalid, if_err, d_rvalid}); end
        checks++; if (if_rdata !== exp_word) begin errors++; $display("FAIL fetch_rdata got=%h exp=%h", if_rdata, exp_word); end
        model_adv();
    endtask

    task automatic test_write();
        logic [31:0] old_word;
        old_word = gm[1];
        apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1004, 32'hAABB_CCDD, 4'b0011);
        checks++; if (mem_we !== 4'b0011) begin errors++; $display("FAIL wr_we got=%b exp=0011", mem_we); end
        checks++; if (mem_addr !== 10'd1 || mem_wdata !== 32'hAABB_CCDD) begin errors++; $display("FAIL wr_addr got=%0d/%h exp=1/aabbccdd", mem_addr, mem_wdata); end
        model_adv();
        apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
        checks++; if ({d_rvalid, d_err, if_rvalid} !== 3'b100 || d_rdata !== 32'd0) begin errors++; $display("FAIL wr_rsp got=%b/%h exp=100/0", {d_rvalid, d_err, if_rvalid}, d_rdata); end
        model_adv();
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (d_rdata !== {old_word[31:16], 16'hCCDD}) begin errors++; $display("FAIL wr_readback got=%h exp=%h", d_rdata, {old_word[31:16], 16'hCCDD}); end
        model_adv();
    endtask

    task automatic test_errors();
        apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
        model_adv();
        apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_1002, 32'hFFFF_FFFF, 4'hF);
        checks++; if ({d_rvalid, d_err} !== 2'b11 || d_rdata !== 32'd0) begin errors++; $display("FAIL err_rd got=%b/%h exp=11/0", {d_rvalid, d_err}, d_rdata); end
        checks++; if (mem_we !== 4'b0000 || d_gnt !== 1'b1) begin errors++; $display("FAIL err_wr_we got=%b gnt=%b exp=0000 gnt=1", mem_we, d_gnt); end
        model_adv();
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if ({d_rvalid, d_err, if_rvalid} !== 3'b110) begin errors++; $display("FAIL err_wr_rsp got=%b exp=110", {d_rvalid, d_err, if_rvalid}); end
        model_adv();
    endtask

    task automatic test_starve();
        for (int k = 0; k < 15; k++) begin
            apply(1'b1, 1'b1, 32'h0000_1010, 1'b1, 1'b0, 32'h0000_1020, 32'h0, 4'h0);
            checks++;
            if ({if_gnt, d_gnt} !== ((k % 5 == 4) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL starve_k%0d got=%b exp=%b", k, {if_gnt, d_gnt}, (k % 5 == 4) ? 2'b10 : 2'b01);
            end
            model_adv();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w2, w1;
        w2 = gm[2]; w1 = gm[1];
        apply(1'b1, 1'b1, 32'h0000_1008, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        model_adv();
        apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
        checks++; if ({if_rvalid, d_rvalid, d_gnt} !== 3'b101 || if_rdata !== w2) begin errors++; $display("FAIL b2b_1 got=%b/%h exp=101/%h", {if_rvalid, d_rvalid, d_gnt}, if_rdata, w2); end
        model_adv();
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if ({if_rvalid, d_rvalid} !== 2'b01 || d_rdata !== w1 || if_rdata !== 32'd0) begin errors++; $display("FAIL b2b_2 got=%b/%h exp=01/%h", {if_rvalid, d_rvalid}, d_rdata, w1); end
        model_adv();
    endtask

    task automatic test_reset_drop();
        apply(1'b1, 1'b1, 32'h0000_1010, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL drop_gnt got=%b exp=1", if_gnt); end
        model_adv();
        for (int c = 0; c < 2; c++) begin
            apply(1'b0, 1'b1, 32'h0000_1010, 1'b1, 1'b1, 32'h0000_1014, 32'h5555_AAAA, 4'hF);
            checks++; if ({if_rvalid, d_rvalid, if_gnt, d_gnt} !== 4'b0000 || mem_we !== 4'b0000) begin errors++; $display("FAIL drop_rst%0d got=%b we=%b exp=0", c, {if_rvalid, d_rvalid, if_gnt, d_gnt}, mem_we); end
            model_adv();
        end
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b1, 32'h0000_1010, 1'b1, 1'b0, 32'h0000_1014, 32'h0, 4'h0);
            if (k == 0) begin
                checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL drop_after got=%b exp=0", if_rvalid); end
            end
            model_adv();
        end
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        model_adv();
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, 1'b1, 32'h0000_1010, 1'b1, 1'b0, 32'h0000_1014, 32'h0, 4'h0);
            checks++; if ({if_gnt, d_gnt} !== ((k == 4) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL drop_starve_k%0d got=%b", k, {if_gnt, d_gnt}); end
            model_adv();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(7))
            0:       return $urandom();
            1:       return {20'd1, 10'($urandom()), 2'($urandom_range(3, 1))};
            2:       return {20'd2, 10'($urandom()), 2'b00};
            default: return {20'd1, 10'($urandom_range(15)), 2'b00};
        endcase
    endfunction

    task automatic test_random();
        logic        hold_if, hold_d, r, ir, dr, dw;
        logic [31:0] ia, da, dd;
        logic [3:0]  be;
        hold_if = 0; hold_d = 0; ia = 0; da = 0; dw = 0; dd = 0; be = 0;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(63) != 0);
            ir = hold_if ? ($urandom_range(7) != 0) : ($urandom_range(2) != 0);
            dr = hold_d ? ($urandom_range(7) != 0) : ($urandom_range(2) != 0);
            if (!hold_if) ia = rand_addr();
            if (!hold_d) begin
                da = rand_addr(); dw = 1'($urandom_range(1)); dd = $urandom(); be = 4'($urandom());
            end
            apply(r, ir, ia, dr, dw, da, dd, be);
            checks++; if (if_gnt !== e_if_gnt) begin errors++; $display("FAIL rnd_if_gnt n=%0d got=%b exp=%b", n, if_gnt, e_if_gnt); end
            checks++; if (d_gnt !== e_d_gnt) begin errors++; $display("FAIL rnd_d_gnt n=%0d got=%b exp=%b", n, d_gnt, e_d_gnt); end
            checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr n=%0d got=%0d exp=%0d", n, mem_addr, e_addr); end
            checks++; if (mem_we !== e_we) begin errors++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, mem_we, e_we); end
            checks++; if (mem_wdata !== e_wdata) begin errors++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, mem_wdata, e_wdata); end
            checks++; if ({if_rvalid, if_err} !== {e_if_rv, e_if_err}) begin errors++; $display("FAIL rnd_if_rsp n=%0d got=%b exp=%b", n, {if_rvalid, if_err}, {e_if_rv, e_if_err}); end
            checks++; if (if_rdata !== e_if_rdata) begin errors++; $display("FAIL rnd_if_rdata n=%0d got=%h exp=%h", n, if_rdata, e_if_rdata); end
            checks++; if ({d_rvalid, d_err} !== {e_d_rv, e_d_err}) begin errors++; $display("FAIL rnd_d_rsp n=%0d got=%b exp=%b", n, {d_rvalid, d_err}, {e_d_rv, e_d_err}); end
            checks++; if (d_rdata !== e_d_rdata) begin errors++; $display("FAIL rnd_d_rdata n=%0d got=%h exp=%h", n, d_rdata, e_d_rdata); end
            hold_if = r && ir && !e_if_gnt;
            hold_d  = r && dr && !e_d_gnt;
            model_adv();
        end
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
        starve = 0; p_if_v = 0; p_d_v = 0; p_if_err = 0; p_d_err = 0;
        p_if_data = '0; p_d_data = '0; last_addr = '0;
        test_reset();
        test_fetch();
        test_write();
        test_errors();
        test_starve();
        test_back_to_back();
        test_reset_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
